mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_if.sv | 25 ++
 rtl/mux_arbiter.sv | 78 +++++++
 tb/tb_mux_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mux_arbiter_if.sv
// Requester/output bundle shared by the two-way mux arbiter and its users.
// Latency and backpressure are set by the arbiter; this file only groups the signals.
interface mux_arbiter_if #(
    parameter int WIDTH = 1
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] line0;
    logic [WIDTH-1:0] line1;
    logic             grant0;
    logic             grant1;
    logic             select;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output req0, req1, line0, line1,
        input  grant0, grant1, select, out, out_valid
    );

    modport slave (
        input  req0, req1, line0, line1,
        output grant0, grant1, select, out, out_valid
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-way round-robin mux arbiter; a grant is capped at MAX_HOLD cycles under contention.
// Latency: 1 cycle req->grant; backpressure: none, a losing requester simply waits.
module mux_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_arbiter_if.slave   bus
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          last_served, last_nxt;
    logic          select_q, select_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last_served <= 1'b1;
            select_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            last_served <= last_nxt;
            select_q    <= select_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_cnt;
        last_nxt   = last_served;
        select_nxt = select_q;

        unique case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) state_nxt = last_served ? G0 : G1;
                else if (bus.req0)        state_nxt = G0;
                else if (bus.req1)        state_nxt = G1;
            end
            G0: begin
                if (!bus.req0)                          state_nxt = bus.req1 ? G1 : IDLE;
                else if (bus.req1 && hold_cnt == HOLD_LAST) state_nxt = G1;
            end
            G1: begin
                if (!bus.req1)                          state_nxt = bus.req0 ? G0 : IDLE;
                else if (bus.req0 && hold_cnt == HOLD_LAST) state_nxt = G0;
            end
            default: state_nxt = IDLE;
        endcase

        // Any entry into a grant state restarts tenure; staying put saturates it.
        if (state_nxt != state && state_nxt != IDLE) begin
            hold_nxt   = '0;
            last_nxt   = (state_nxt == G1);
            select_nxt = (state_nxt == G1);
        end else if (state_nxt != IDLE && hold_cnt != HOLD_LAST) begin
            hold_nxt   = hold_cnt + HW'(1);
        end
    end

    assign bus.grant0    = (state == G0);
    assign bus.grant1    = (state == G1);
    assign bus.select    = select_q;
    assign bus.out_valid = bus.grant0 | bus.grant1;
    assign bus.out       = bus.grant0 ? bus.line0 :
                           bus.grant1 ? bus.line1 : '0;
endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios with literal expectations plus a per-cycle model compare.
module tb_mux_arbiter;
    localparam int WIDTH    = 1;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   cmp_en = 1'b0;

    mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: who owns the output, how many cycles it has owned it, who won last.
    int   m_owner;
    int   m_tenure;
    int   m_last;
    logic m_sel;

    always @(posedge clk or negedge rst_n) begin
        int n;
        int mine;
        int other;
        if (!rst_n) begin
            m_owner  = -1;
            m_tenure = 0;
            m_last   = 1;
            m_sel    = 1'b0;
        end else begin
            n = m_owner;
            if (m_owner < 0) begin
                if (bus.req0 && bus.req1) n = 1 - m_last;
                else if (bus.req0)        n = 0;
                else if (bus.req1)        n = 1;
            end else begin
                mine  = (m_owner == 0) ? int'(bus.req0) : int'(bus.req1);
                other = (m_owner == 0) ? int'(bus.req1) : int'(bus.req0);
                if (mine == 0)                            n = (other != 0) ? 1 - m_owner : -1;
                else if (other != 0 && m_tenure >= MAX_HOLD) n = 1 - m_owner;
            end
            if (n >= 0 && n != m_owner) begin
                m_tenure = 1;
                m_last   = n;
                m_sel    = (n == 1);
            end else if (n >= 0) begin
                m_tenure = m_tenure + 1;
            end
            m_owner = n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [WIDTH-1:0] e_out;
        if (cmp_en) begin
            e_out = (m_owner == 0) ? bus.line0 : (m_owner == 1) ? bus.line1 : '0;
            chk("model grant0",    32'(bus.grant0),    32'(m_owner == 0));
            chk("model grant1",    32'(bus.grant1),    32'(m_owner == 1));
            chk("model select",    32'(bus.select),    32'(m_sel));
            chk("model out_valid", 32'(bus.out_valid), 32'(m_owner >= 0));
            chk("model out",       32'(bus.out),       32'(e_out));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.line0 = '0;
        bus.line1 = '0;
        #2;
        chk("rst grant0",    32'(bus.grant0),    32'd0);
        chk("rst grant1",    32'(bus.grant1),    32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out",       32'(bus.out),       32'd0);
        chk("rst select",    32'(bus.select),    32'd0);
        cmp_en = 1'b1;
        tick();
        tick();

        // Single request straight out of reset
        rst_n     = 1'b1;
        bus.req0  = 1'b1;
        bus.line0 = 1'b1;
        tick();
        chk("single grant0",    32'(bus.grant0),    32'd1);
        chk("single grant1",    32'(bus.grant1),    32'd0);
        chk("single select",    32'(bus.select),    32'd0);
        chk("single out",       32'(bus.out),       32'd1);
        chk("single out_valid", 32'(bus.out_valid), 32'd1);
        bus.req0 = 1'b0;
        tick();

        // Simultaneous requests after a fresh reset: 4 cycles each, requester 0 first
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.line0 = 1'b1;
        bus.line1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rr grant0", 32'(bus.grant0), 32'(((i / 4) % 2) == 0));
            chk("rr grant1", 32'(bus.grant1), 32'(((i / 4) % 2) == 1));
            chk("rr select", 32'(bus.select), 32'((i / 4) % 2));
        end
        tick();
        chk("rr third switch grant1", 32'(bus.grant1), 32'd1);

        // Handoff G1 -> G0 without an idle cycle
        bus.req1 = 1'b0;
        tick();
        chk("handoff grant0",    32'(bus.grant0),    32'd1);
        chk("handoff grant1",    32'(bus.grant1),    32'd0);
        chk("handoff out_valid", 32'(bus.out_valid), 32'd1);
        chk("handoff out",       32'(bus.out),       32'd1);

        // Release to idle
        bus.req0 = 1'b0;
        tick();
        chk("idle out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle out",       32'(bus.out),       32'd0);
        chk("idle select",    32'(bus.select),    32'd0);
        chk("idle grant0",    32'(bus.grant0),    32'd0);

        // Lone holder is never preempted
        bus.req1  = 1'b1;
        bus.line1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("lone grant1", 32'(bus.grant1), 32'd1);
        end
        chk("lone select", 32'(bus.select), 32'd1);

        // Asynchronous reset between edges while requester 1 holds the output
        #2;
        rst_n = 1'b0;
        #1;
        chk("async grant1",    32'(bus.grant1),    32'd0);
        chk("async select",    32'(bus.select),    32'd0);
        chk("async out_valid", 32'(bus.out_valid), 32'd0);
        chk("async out",       32'(bus.out),       32'd0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        chk("held in reset grant0", 32'(bus.grant0), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post-reset grant0", 32'(bus.grant0), 32'd1);
        chk("post-reset grant1", 32'(bus.grant1), 32'd0);

        // Mixed traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            bus.req0  = ($urandom_range(0, 3) != 0);
            bus.req1  = ($urandom_range(0, 3) != 0);
            bus.line0 = WIDTH'($urandom);
            bus.line1 = WIDTH'($urandom);
            tick();
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
